// File: rtl/lsu_ctrl.sv
// Load/store unit: funct3 decode, valid/ack memory handshake, load extension, watchdog.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests complete with rsp_err instead of accessing memory.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [29:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          reject;
  logic [3:0]    be_enc;
  logic [31:0]   wd_enc;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ld_data;

  always_comb begin
    reject = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
             (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    reject = reject ||
             (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`endif

    // Shifts ignore low offset bits for h/w, which is exactly the non-trapping misaligned behaviour.
    case (req_funct3[1:0])
      2'b00: begin
        be_enc = 4'b0001 << req_addr[1:0];
        wd_enc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_enc = 4'b0011 << {req_addr[1], 1'b0};
        wd_enc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_enc = 4'b1111;
        wd_enc = req_wdata;
      end
    endcase
    if (!req_we) be_enc = 4'b1111;

    case (off_q)
      2'b00:   sel_byte = mem_rdata[7:0];
      2'b01:   sel_byte = mem_rdata[15:8];
      2'b10:   sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q)
      3'b000:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_data = {24'd0, sel_byte};
      3'b001:  ld_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_data = {16'd0, sel_half};
      default: ld_data = mem_rdata;
    endcase
    if (we_q) ld_data = '0;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          addr_d  = req_addr[31:2];
          be_d    = be_enc;
          wdata_d = wd_enc;
          rdata_d = '0;
          err_d   = reject;
          state_d = reject ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Ack takes priority over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          rdata_d = ld_data;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

endmodule
